// File: rtl/sa_pkg.sv
// Shared constants and types for the 4x4 systolic array feeders.
package sa_pkg;

  localparam int SA_N      = 4;
  localparam int SA_ADDR_W = 6;
  localparam int SA_DATA_W = 16;

  localparam int DRAIN_CYCLES = SA_N - 1;
  // The capture register drains too, so the FSM waits one cycle beyond the skew depth.
  localparam int DRAIN_LEN    = DRAIN_CYCLES + 1;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_LEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Registered data+valid shift register of DEPTH stages; DEPTH=0 is a wire.
module skew_delay_line #(
  parameter int DEPTH  = 0,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  generate
    if (DEPTH == 0) begin : g_pass
      // clk and rst have no load in the pass-through case.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_data  = in_data;
      assign out_valid = in_valid;
    end else begin : g_shift
      logic [DATA_W-1:0] data_q [DEPTH];
      logic [DEPTH-1:0]  valid_q;

      always_ff @(posedge clk) begin
        // NOTE: the data stages are reset along with valid so an aborted block
        // leaves only zeros behind and b_out stays 0 whenever valid is 0.
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
          valid_q <= '0;
        end else begin
          data_q[0]  <= in_data;
          valid_q[0] <= in_valid;
          for (int k = 1; k < DEPTH; k++) begin
            data_q[k]  <= data_q[k-1];
            valid_q[k] <= valid_q[k-1];
          end
        end
      end

      assign out_data  = data_q[DEPTH-1];
      assign out_valid = valid_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/b_skew_feeder.sv
// Streams a K-row block of B from four memory read ports into the array's
// north edge, with column j delayed j cycles behind column 0.
module b_skew_feeder
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int ADDR_W = SA_ADDR_W,
  parameter int DATA_W = SA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        k_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr_0,
  output logic [ADDR_W-1:0] read_addr_1,
  output logic [ADDR_W-1:0] read_addr_2,
  output logic [ADDR_W-1:0] read_addr_3,
  input  logic [DATA_W-1:0] read_data_0,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] read_data_3,
  output logic [DATA_W-1:0] b_out_0,
  output logic [DATA_W-1:0] b_out_1,
  output logic [DATA_W-1:0] b_out_2,
  output logic [DATA_W-1:0] b_out_3,
  output logic              b_valid_0,
  output logic              b_valid_1,
  output logic              b_valid_2,
  output logic              b_valid_3
);

  feeder_state_t          state;
  logic [4:0]             k_q;
  logic [4:0]             row_cnt;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [ADDR_W-1:0]      addr_q    [N];
  logic [DATA_W-1:0]      rd_data   [N];
  logic [DATA_W-1:0]      cap_data  [N];
  logic [N-1:0]           cap_valid;
  logic [DATA_W-1:0]      skew_data [N];
  logic [N-1:0]           skew_valid;

  assign rd_data[0] = read_data_0;
  assign rd_data[1] = read_data_1;
  assign rd_data[2] = read_data_2;
  assign rd_data[3] = read_data_3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      k_q       <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      cap_valid <= '0;
      for (int j = 0; j < N; j++) begin
        addr_q[j]   <= '0;
        cap_data[j] <= '0;
      end
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values regardless of statement order.
      done      <= 1'b0;
      cap_valid <= '0;
      for (int j = 0; j < N; j++) cap_data[j] <= '0;

      case (state)
        IDLE: begin
          if (start && (k_rows != 5'd0)) begin
            state   <= RUN;
            busy    <= 1'b1;
            k_q     <= k_rows;
            row_cnt <= '0;
            for (int j = 0; j < N; j++) addr_q[j] <= base_addr + ADDR_W'(j);
          end
        end
        RUN: begin
          for (int j = 0; j < N; j++) cap_data[j] <= rd_data[j];
          cap_valid <= '1;
          // Addresses stay on the last row once the block is exhausted.
          if (row_cnt == k_q - 5'd1) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 5'd1;
            for (int j = 0; j < N; j++) addr_q[j] <= addr_q[j] + ADDR_W'(N);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_CNT_W'(DRAIN_LEN - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar j = 0; j < N; j++) begin : g_col
      skew_delay_line #(
        .DEPTH (j),
        .DATA_W(DATA_W)
      ) u_skew (
        .clk      (clk),
        .rst      (rst),
        .in_data  (cap_data[j]),
        .in_valid (cap_valid[j]),
        .out_data (skew_data[j]),
        .out_valid(skew_valid[j])
      );
    end
  endgenerate

  assign read_addr_0 = addr_q[0];
  assign read_addr_1 = addr_q[1];
  assign read_addr_2 = addr_q[2];
  assign read_addr_3 = addr_q[3];

  assign b_out_0 = skew_data[0];
  assign b_out_1 = skew_data[1];
  assign b_out_2 = skew_data[2];
  assign b_out_3 = skew_data[3];

  assign b_valid_0 = skew_valid[0];
  assign b_valid_1 = skew_valid[1];
  assign b_valid_2 = skew_valid[2];
  assign b_valid_3 = skew_valid[3];

endmodule

// File: tb/tb_b_skew_feeder.sv
// Self-checking bench for b_skew_feeder against a cycle-offset reference model.
module tb_b_skew_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [4:0]  k_rows;
  logic        busy;
  logic        done;
  logic [5:0]  read_addr [4];
  logic [15:0] read_data [4];
  logic [15:0] b_out     [4];
  logic [3:0]  b_valid;

  logic [15:0] mem [64];
  logic [5:0]  hold_addr [4];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory model.
  always_comb begin
    for (int j = 0; j < 4; j++) read_data[j] = mem[read_addr[j]];
  end

  b_skew_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .k_rows     (k_rows),
    .busy       (busy),
    .done       (done),
    .read_addr_0(read_addr[0]),
    .read_addr_1(read_addr[1]),
    .read_addr_2(read_addr[2]),
    .read_addr_3(read_addr[3]),
    .read_data_0(read_data[0]),
    .read_data_1(read_data[1]),
    .read_data_2(read_data[2]),
    .read_data_3(read_data[3]),
    .b_out_0    (b_out[0]),
    .b_out_1    (b_out[1]),
    .b_out_2    (b_out[2]),
    .b_out_3    (b_out[3]),
    .b_valid_0  (b_valid[0]),
    .b_valid_1  (b_valid[1]),
    .b_valid_2  (b_valid[2]),
    .b_valid_3  (b_valid[3])
  );

  // Pulse start for one cycle; returns #1 into the first RUN cycle (t0).
  task automatic launch(input logic [5:0] base, input int k);
    start     = 1'b1;
    base_addr = base;
    k_rows    = 5'(k);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 6'($urandom);
    k_rows    = 5'($urandom);
  endtask

  // Check cycles t0+0 .. t0+last_c of a block against the timing rules.
  // A stray start (base 32) is pulsed in cycle t0+intrude_at.
  task automatic test_stream_window(input logic [5:0] base, input int k,
                                    input int intrude_at, input int last_c);
    for (int c = 0; c <= last_c; c++) begin
      int rr;
      if (c == intrude_at) begin
        start     = 1'b1;
        base_addr = 6'd32;
        k_rows    = 5'd3;
      end
      @(negedge clk);
      rr = (c < k) ? c : k - 1;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy c=%0d got=%b exp=1", c, busy);
      end
      vectors++;
      if (done !== (c == k + 4)) begin
        miscompares++;
        $display("FAIL done c=%0d got=%b exp=%b", c, done, (c == k + 4));
      end
      for (int j = 0; j < 4; j++) begin
        logic [5:0]  exp_a;
        logic        exp_v;
        logic [15:0] exp_d;
        exp_a = 6'((int'(base) + 4 * rr + j) % 64);
        exp_v = (c >= 1 + j) && (c <= k + j);
        exp_d = exp_v ? mem[6'((int'(base) + 4 * (c - 1 - j) + j) % 64)] : 16'd0;
        vectors++;
        if (read_addr[j] !== exp_a) begin
          miscompares++;
          $display("FAIL read_addr_%0d c=%0d got=%0d exp=%0d", j, c, read_addr[j], exp_a);
        end
        vectors++;
        if (b_valid[j] !== exp_v) begin
          miscompares++;
          $display("FAIL b_valid_%0d c=%0d got=%b exp=%b", j, c, b_valid[j], exp_v);
        end
        vectors++;
        if (b_out[j] !== exp_d) begin
          miscompares++;
          $display("FAIL b_out_%0d c=%0d got=%0d exp=%0d", j, c, b_out[j], exp_d);
        end
        if (c == last_c) hold_addr[j] = exp_a;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Idle cycles: no activity, addresses held at their last value.
  task automatic test_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ctrl c=%0d busy=%b done=%b exp=0/0", c, busy, done);
      end
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (b_valid[j] !== 1'b0 || b_out[j] !== 16'd0 || read_addr[j] !== hold_addr[j]) begin
          miscompares++;
          $display("FAIL idle_col_%0d c=%0d valid=%b out=%0d addr=%0d exp=0/0/%0d",
                   j, c, b_valid[j], b_out[j], read_addr[j], hold_addr[j]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    base_addr = 6'd17;
    k_rows = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) hold_addr[j] = 6'd0;
    test_idle(1);
    rst = 1'b0;
    test_idle(3);
  endtask

  task automatic test_basic();
    launch(6'd0, 4);
    test_stream_window(6'd0, 4, -1, 8);
    test_idle(2);
  endtask

  task automatic test_wrap();
    launch(6'd60, 2);
    test_stream_window(6'd60, 2, -1, 6);
    test_idle(2);
  endtask

  task automatic test_single_row();
    launch(6'd5, 1);
    test_stream_window(6'd5, 1, -1, 5);
    test_idle(2);
  endtask

  task automatic test_start_while_busy();
    launch(6'd9, 16);
    test_stream_window(6'd9, 16, 3, 20);
    test_idle(4);
  endtask

  task automatic test_zero_k();
    start = 1'b1;
    base_addr = 6'd40;
    k_rows = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    test_idle(6);
  endtask

  task automatic test_mid_reset();
    launch(6'd20, 8);
    test_stream_window(6'd20, 8, -1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) hold_addr[j] = 6'd0;
    test_idle(14);
    launch(6'd0, 4);
    test_stream_window(6'd0, 4, -1, 8);
    test_idle(1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic [5:0] b;
      int k;
      int gap;
      b   = 6'($urandom);
      k   = int'($urandom_range(1, 16));
      gap = int'($urandom_range(0, 2));
      launch(b, k);
      test_stream_window(b, k, -1, k + 4);
      if (gap != 0) test_idle(gap);
    end
    test_idle(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    k_rows      = '0;
    for (int a = 0; a < 64; a++) mem[a] = 16'(a + 100);
    for (int j = 0; j < 4; j++) hold_addr[j] = 6'd0;
    @(posedge clk); #1;

    test_reset();
    test_basic();
    test_wrap();
    test_single_row();
    test_start_while_busy();
    test_zero_k();
    test_mid_reset();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
